// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
// It grants one byte per frame and holds tx_data_o until the transmitter drops tx_busy_i.
module uart_tx_scheduler #(
  parameter  int NUM_REQ      = 4,
  parameter  int BUSY_TIMEOUT = 4,
  localparam int ID_W         = $clog2(NUM_REQ),
  localparam int CNT_W        = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                   baud_clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_busy_i,
  output logic [ID_W-1:0]        grant_id_o,
  output logic                   grant_valid_o,
  output logic                   timeout_err_o,
  input  logic                   err_clear_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    WAIT_FALL
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               tx_start_q, tx_start_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic               timeout_err_q, timeout_err_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

  // Requester index base+k, wrapping NUM_REQ-1 -> 0 (NUM_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_REQ) sum -= NUM_REQ;
    return ID_W'(sum);
  endfunction

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid_i[wrap_add(rr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_q, k);
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case leaves
    // one unassigned; an unassigned path would infer a latch.
    state_d       = state_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    req_ready_d   = '0;
    tx_start_d    = 1'b0;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    timeout_err_d = timeout_err_q & ~err_clear_i;

    unique case (state_q)
      IDLE: begin
        if (!tx_busy_i && pick_found) begin
          tx_data_d             = req_data_i[8*int'(pick_idx) +: 8];
          req_ready_d[pick_idx] = 1'b1;
          tx_start_d            = 1'b1;
          grant_id_d            = pick_idx;
          grant_valid_d         = 1'b1;
          rr_d                  = wrap_add(pick_idx, 1);
          cnt_d                 = '0;
          state_d               = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (tx_busy_i) begin
          state_d = WAIT_FALL;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // The byte is dropped; the error flag is set last so it beats err_clear_i.
          timeout_err_d = 1'b1;
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_FALL: begin
        if (!tx_busy_i) begin
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      cnt_q         <= '0;
      tx_data_q     <= 8'h00;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      req_ready_q   <= req_ready_d;
      tx_start_q    <= tx_start_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign grant_id_o    = grant_id_q;
  assign grant_valid_o = grant_valid_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a one-bit-per-cycle UART transmitter model.
// Expected values are hand-computed constants; the model only supplies tx_busy and the line.
module tb_uart_tx_scheduler;
  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 4;
  localparam int ID_W         = 2;
  // tx_busy is high from the tx_start cycle through the stop bit: 1 + 10 bit times.
  localparam int FRAME_LEN    = 11;

  logic                 baud_clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_valid;
  logic                 timeout_err;
  logic                 err_clear;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .baud_clk     (baud_clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .tx_data_o    (tx_data),
    .tx_start_o   (tx_start),
    .tx_busy_i    (tx_busy),
    .grant_id_o   (grant_id),
    .grant_valid_o(grant_valid),
    .timeout_err_o(timeout_err),
    .err_clear_i  (err_clear)
  );

  always #5 baud_clk = ~baud_clk;

  // Transmitter model: picks up tx_start on the next edge, then sends start, 8 data LSB first, stop.
  logic       tx_en;
  logic       tx_active;
  logic [9:0] tx_frame;
  logic [3:0] tx_n;
  logic       tx_line;

  always @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      tx_active <= 1'b0;
      tx_n      <= 4'd0;
      tx_frame  <= '1;
    end else if (!tx_active) begin
      if (tx_en && tx_start) begin
        tx_frame  <= {1'b1, tx_data, 1'b0};
        tx_active <= 1'b1;
        tx_n      <= 4'd0;
      end
    end else begin
      if (tx_n == 4'd9) tx_active <= 1'b0;
      tx_n <= tx_n + 4'd1;
    end
  end

  assign tx_line = tx_active ? tx_frame[tx_n] : 1'b1;
  assign tx_busy = tx_en & (tx_start | tx_active);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]      st_data[$];
  logic [ID_W-1:0] st_gid[$];
  int              st_cyc[$];
  logic            line_bits[$];
  int              ready_cnt[NUM_REQ];
  logic [NUM_REQ-1:0] hold_valid;
  int              busy_viol;
  int              data_viol;
  logic [7:0]      last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    st_data.delete();
    st_gid.delete();
    st_cyc.delete();
    line_bits.delete();
    for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
    busy_viol = 0;
    data_viol = 0;
  endtask

  // One cycle: sample outputs on the falling edge, record events, act as the requesters.
  task automatic step();
    @(negedge baud_clk);
    cyc++;
    if (tx_start) begin
      if (tx_active) busy_viol++;
      st_data.push_back(tx_data);
      st_gid.push_back(grant_id);
      st_cyc.push_back(cyc);
      last_data = tx_data;
    end
    if (grant_valid && tx_data !== last_data) data_viol++;
    if (tx_active) line_bits.push_back(tx_line);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        ready_cnt[i]++;
        if (hold_valid[i]) req_data[8*i +: 8] = req_data[8*i +: 8] + 8'd1;
        else               req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    logic idle_now;
    idle_now = !grant_valid && (req_valid == '0) && !tx_active;
    while (!idle_now && n < budget) begin
      step();
      n++;
      idle_now = !grant_valid && (req_valid == '0) && !tx_active;
    end
    check(tag, {31'b0, idle_now}, 32'd1);
  endtask

  task automatic wait_starts(input string tag, input int count, input int budget);
    int n = 0;
    while (st_data.size() < count && n < budget) begin
      step();
      n++;
    end
    check(tag, st_data.size(), count);
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    req_valid  = '0;
    hold_valid = '0;
    err_clear  = 1'b0;
    tx_en      = 1'b1;
    repeat (2) @(negedge baud_clk);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  req_ready,   '0);
    check({tag, "_data"},   tx_data,     8'h00);
    check({tag, "_start"},  tx_start,    1'b0);
    check({tag, "_gid"},    grant_id,    '0);
    check({tag, "_gvalid"}, grant_valid, 1'b0);
    check({tag, "_terr"},   timeout_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] bits_v;
    int c_set;

    reset      = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    hold_valid = '0;
    err_clear  = 1'b0;
    tx_en      = 1'b1;
    last_data  = 8'h00;
    clear_log();
    @(negedge baud_clk);
    check_reset_outputs("rst");
    apply_reset();

    // Single byte from requester 2; line must read 0,1,0,1,0,0,1,0,1,1.
    req_data[8*2 +: 8] = 8'hA5;
    req_valid[2] = 1'b1;
    c_set = cyc;
    step();
    check("t1_latency", st_cyc.size() > 0 ? st_cyc[0] - c_set : -1, 1);
    wait_idle("t1_idle", 60);
    check("t1_starts", st_data.size(), 1);
    check("t1_data",   st_data[0], 8'hA5);
    check("t1_gid",    st_gid[0], 2);
    check("t1_ready2", ready_cnt[2], 1);
    check("t1_hold",   data_viol, 0);
    check("t1_nbits",  line_bits.size(), 10);
    for (int k = 0; k < 10; k++) bits_v[k] = (k < line_bits.size()) ? line_bits[k] : 1'bx;
    check("t1_line",   bits_v, 10'b1101001010);

    // All requesters at once after reset: order 0,1,2,3.
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
    req_valid = '1;
    wait_idle("t2_idle", 200);
    check("t2_starts", st_data.size(), 4);
    for (int i = 0; i < NUM_REQ; i++) begin
      check($sformatf("t2_data%0d", i), st_data[i], 8'(8'h10 + i));
      check($sformatf("t2_gid%0d", i),  st_gid[i], i);
    end
    check("t2_busy_viol", busy_viol, 0);
    check("t2_hold", data_viol, 0);

    // Requester 1 streaming with continuous valid.
    apply_reset();
    req_data[8*1 +: 8] = 8'h40;
    hold_valid[1] = 1'b1;
    req_valid[1]  = 1'b1;
    wait_starts("t3_starts", 3, 100);
    hold_valid[1] = 1'b0;
    req_valid[1]  = 1'b0;
    wait_idle("t3_idle", 60);
    check("t3_data0", st_data[0], 8'h40);
    check("t3_data1", st_data[1], 8'h41);
    check("t3_data2", st_data[2], 8'h42);
    check("t3_gid2",  st_gid[2], 1);
    check("t3_space1", st_cyc[1] - st_cyc[0], FRAME_LEN + 2);
    check("t3_space2", st_cyc[2] - st_cyc[1], FRAME_LEN + 2);
    check("t3_ready1", ready_cnt[1], 3);

    // Transmitter stubbed: timeout, drop, clear, then set-wins-over-clear.
    apply_reset();
    tx_en = 1'b0;
    req_data[8*0 +: 8] = 8'h77;
    req_valid[0] = 1'b1;
    step();
    check("t4_start", tx_start, 1'b1);
    repeat (BUSY_TIMEOUT - 1) step();
    check("t4_terr_early", timeout_err, 1'b0);
    check("t4_gv_early",   grant_valid, 1'b1);
    step();
    check("t4_terr", timeout_err, 1'b1);
    check("t4_gv",   grant_valid, 1'b0);
    repeat (3) step();
    check("t4_no_retry", st_data.size(), 1);
    check("t4_sticky",   timeout_err, 1'b1);
    err_clear = 1'b1;
    step();
    check("t4_cleared", timeout_err, 1'b0);
    req_valid[0] = 1'b1;
    step();
    check("t4_regrant", tx_start, 1'b1);
    repeat (BUSY_TIMEOUT) step();
    check("t4_set_wins", timeout_err, 1'b1);
    step();
    check("t4_clear_after", timeout_err, 1'b0);
    err_clear = 1'b0;

    // Reset in WAIT_FALL; pending requester 3 granted afterwards.
    apply_reset();
    req_data[8*2 +: 8] = 8'h55;
    req_valid[2] = 1'b1;
    wait_starts("t5_first", 1, 20);
    repeat (4) step();
    check("t5_in_frame", grant_valid, 1'b1);
    check("t5_busy",     tx_busy, 1'b1);
    req_data[8*3 +: 8] = 8'h66;
    req_valid[3] = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_outputs("t5_rst");
    repeat (2) @(negedge baud_clk);
    clear_log();
    reset = 1'b0;
    step();
    check("t5_start", tx_start, 1'b1);
    check("t5_gid",   grant_id, 3);
    check("t5_data",  tx_data, 8'h66);
    wait_idle("t5_idle", 60);
    check("t5_ready3", ready_cnt[3], 1);

    // Requester 0 withdraws before it is reached; only requester 1 is served.
    apply_reset();
    req_data[8*2 +: 8] = 8'h20;
    req_valid[2] = 1'b1;
    wait_starts("t6_first", 1, 20);
    repeat (3) step();
    req_data[8*0 +: 8] = 8'h30;
    req_data[8*1 +: 8] = 8'h31;
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    repeat (3) step();
    req_valid[0] = 1'b0;
    wait_idle("t6_idle", 100);
    check("t6_starts", st_data.size(), 2);
    check("t6_gid",    st_gid[1], 1);
    check("t6_data",   st_data[1], 8'h31);
    check("t6_ready0", ready_cnt[0], 0);
    check("t6_ready1", ready_cnt[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
